// File: rtl/div_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared divider.
// The arbiter takes the slave view; the environment drives the master view.
interface div_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic [N-1:0]   ack;
    logic [W-1:0]   rsp_quotient;
    logic [W-1:0]   rsp_remainder;
    logic           rsp_err;
    logic           busy;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_done;
    logic [W-1:0]   div_quotient;
    logic [W-1:0]   div_remainder;

    modport slave (
        input  req, req_dividend, req_divisor,
        input  div_done, div_quotient, div_remainder,
        output ack, rsp_quotient, rsp_remainder, rsp_err, busy,
        output div_start, div_dividend, div_divisor
    );

    modport master (
        output req, req_dividend, req_divisor,
        output div_done, div_quotient, div_remainder,
        input  ack, rsp_quotient, rsp_remainder, rsp_err, busy,
        input  div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one sequential divider among N requesters,
// with divide-by-zero short-circuit and a bounded wait for done.
module div_arbiter #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 32
) (
    input logic          clk,
    input logic          rst,
    div_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t         state_q;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  win_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   ack_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   rem_q;
    logic           err_q;
    logic           busy_q;
    logic           start_q;
    logic [W-1:0]   dvd_q;
    logic [W-1:0]   dvs_q;

    logic           gnt_vld_d;
    logic [IW-1:0]  gnt_idx_d;
    logic [W-1:0]   gnt_dvd_d;
    logic [W-1:0]   gnt_dvs_d;

    // Slot k positions after the last winner, wrapping at N.
    function automatic logic [IW-1:0] rr_slot(
        input logic [IW-1:0] p,
        input int            k
    );
        int j;
        j = int'(p) + k;
        if (j >= N) j = j - N;
        return IW'(j);
    endfunction

    // Scan farthest-first so the nearest requester after ptr wins.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_idx_d = '0;
        for (int k = N; k >= 1; k--) begin
            if (bus.req[rr_slot(ptr_q, k)]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = rr_slot(ptr_q, k);
            end
        end
    end

    // Pick the winner's operand slices.
    always_comb begin
        gnt_dvd_d = '0;
        gnt_dvs_d = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx_d == IW'(i)) begin
                gnt_dvd_d = bus.req_dividend[i*W +: W];
                gnt_dvs_d = bus.req_divisor[i*W +: W];
            end
        end
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (gnt_vld_d) begin
                        win_q  <= gnt_idx_d;
                        dvd_q  <= gnt_dvd_d;
                        dvs_q  <= gnt_dvs_d;
                        busy_q <= 1'b1;
                        if (gnt_dvs_d != '0) begin
                            start_q <= 1'b1;
                            state_q <= LAUNCH;
                        end else begin
                            quo_q   <= '1;
                            rem_q   <= gnt_dvd_d;
                            err_q   <= 1'b1;
                            ack_q   <= N'(1) << gnt_idx_d;
                            state_q <= RESP;
                        end
                    end
                end
                LAUNCH: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.div_done) begin
                        quo_q   <= bus.div_quotient;
                        rem_q   <= bus.div_remainder;
                        err_q   <= 1'b0;
                        ack_q   <= N'(1) << win_q;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        quo_q   <= '0;
                        rem_q   <= '0;
                        err_q   <= 1'b1;
                        ack_q   <= N'(1) << win_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= win_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack           = ack_q;
    assign bus.rsp_quotient  = quo_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_err       = err_q;
    assign bus.busy          = busy_q;
    assign bus.div_start     = start_q;
    assign bus.div_dividend  = dvd_q;
    assign bus.div_divisor   = dvs_q;
endmodule
